// File: rtl/dcache_sa_controller.sv
// dcache_sa_controller: N-way set-associative write-back/write-allocate data cache with true-LRU replacement.
// Defining DCACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt/wb_cnt outputs.
module dcache_sa_controller #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 64,
    parameter int WAYS        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [WORD_W-1:0]             cpu_wdata,
    input  logic [WORD_W/8-1:0]           cpu_byte_en,
    input  logic                          cpu_rw,
    input  logic                          cpu_valid,
    output logic [WORD_W-1:0]             cpu_rdata,
    output logic                          cpu_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [WORD_W*BLOCK_WORDS-1:0] mem_wdata,
    input  logic [WORD_W*BLOCK_WORDS-1:0] mem_rdata,
    output logic                          mem_rw,
    output logic                          mem_valid,
    input  logic                          mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt,
    output logic [31:0]                   wb_cnt
`endif
);
    localparam int BYTES = WORD_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WO_W  = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int LOW_W = WO_W + OFF_W;
    localparam int TAG_W = ADDR_W - IDX_W - LOW_W;
    localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {COMPARE, WRITE_BACK, ALLOCATE} state_t;
    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] line_t;

    state_t              state_q;
    line_t               data_q  [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic                valid_q [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    line_t               line_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [WAY_W-1:0]    vict_q;

    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    idx;
    logic [WO_W-1:0]     woff;
    logic                hit, inv_found, vict_dirty, req, miss, fill, touch;
    logic [WAY_W-1:0]    hit_way, inv_way, lru_way, vict_way, touch_way;
    line_t               vict_line;
    logic [ADDR_W-1:0]   vict_addr, fill_addr;
    logic                unused_addr;

    assign tag         = cpu_addr[ADDR_W-1 -: TAG_W];
    assign idx         = cpu_addr[LOW_W +: IDX_W];
    assign woff        = cpu_addr[OFF_W +: WO_W];
    assign unused_addr = ^cpu_addr;

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        vict_way   = inv_found ? inv_way : lru_way;
        vict_dirty = valid_q[idx][vict_way] && dirty_q[idx][vict_way];
        vict_line  = data_q[idx][vict_way];
        vict_addr  = {tag_q[idx][vict_way], idx, {LOW_W{1'b0}}};
        fill_addr  = {tag, idx, {LOW_W{1'b0}}};
    end

    always_comb begin
        req       = !reset && cpu_valid && state_q == COMPARE;
        cpu_ready = req && hit;
        miss      = req && !hit;
        fill      = !reset && state_q == ALLOCATE && mem_ready;
        touch     = cpu_ready || fill;
        touch_way = fill ? vict_q : hit_way;
        mem_valid = miss || (!reset && state_q != COMPARE);
        mem_rw    = state_q == COMPARE ? miss && vict_dirty : !reset && state_q == WRITE_BACK;
        mem_addr  = !mem_valid ? '0 : !mem_rw ? fill_addr : state_q == COMPARE ? vict_addr : wb_addr_q;
        mem_wdata = !mem_valid ? '0 : state_q == COMPARE ? vict_line : line_q;
        cpu_rdata = cpu_ready ? data_q[idx][hit_way][woff] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COMPARE;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
        end else begin
            if (cpu_ready && cpu_rw)
                dirty_q[idx][hit_way] <= 1'b1;
            unique case (state_q)
                COMPARE: if (miss) begin
                    vict_q    <= vict_way;
                    line_q    <= vict_line;
                    wb_addr_q <= vict_addr;
                    state_q   <= vict_dirty ? WRITE_BACK : ALLOCATE;
                end
                WRITE_BACK: if (mem_ready) state_q <= ALLOCATE;
                ALLOCATE: if (mem_ready) begin
                    valid_q[idx][vict_q] <= 1'b1;
                    dirty_q[idx][vict_q] <= 1'b0;
                    state_q              <= COMPARE;
                end
                default: state_q <= COMPARE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_ready && cpu_rw)
            for (int b = 0; b < BYTES; b++)
                if (cpu_byte_en[b]) data_q[idx][hit_way][woff][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
        if (fill) begin
            data_q[idx][vict_q] <= mem_rdata;
            tag_q[idx][vict_q]  <= tag;
        end
    end

    if (WAYS > 1) begin : g_lru
        logic [WAY_W-1:0] age_q [SETS][WAYS];
        logic [WAY_W-1:0] ref_age;
        assign ref_age = age_q[idx][touch_way];
        always_comb begin
            lru_way = '0;
            for (int w = 1; w < WAYS; w++)
                if (age_q[idx][w] > age_q[idx][lru_way]) lru_way = WAY_W'(w);
        end
        // Using <= lets fills into a cold set (ages all 0) build up the permutation; once full it equals <.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        age_q[s][w] <= '0;
            end else if (touch) begin
                for (int w = 0; w < WAYS; w++)
                    if (WAY_W'(w) != touch_way && age_q[idx][w] <= ref_age)
                        age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
                age_q[idx][touch_way] <= '0;
            end
        end
    end else begin : g_dm
        assign lru_way = '0;
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (cpu_ready && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (miss && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            if (miss && vict_dirty && wb_cnt != '1) wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_sa_controller.sv
// tb_dcache_sa_controller: scoreboard bench; a per-set recency-list cache model predicts CPU data and memory traffic.
module tb_dcache_sa_controller;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
    logic [3:0]   cpu_byte_en;
    logic         cpu_rw, cpu_valid, cpu_ready, mem_rw, mem_valid, mem_ready;
    logic [127:0] mem_wdata, mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

    dcache_sa_controller #(.ADDR_W(32), .WORD_W(32), .BLOCK_WORDS(4), .SETS(64), .WAYS(2)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
        .cpu_rw(cpu_rw), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rw(mem_rw),
        .mem_valid(mem_valid), .mem_ready(mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [21:0] tag; logic dirty; logic [127:0] line;} ent_t;
    typedef struct packed {logic rd; logic [31:0] data;} cexp_t;
    typedef struct packed {logic rw; logic [31:0] addr; logic [127:0] data;} mreq_t;

    ent_t         cm [64][$];
    cexp_t        exp_cpu [$];
    mreq_t        exp_mem [$];
    logic [127:0] ref_mem [logic [31:0]];
    logic [127:0] env_mem [logic [31:0]];
    int           n_chk = 0, n_pass = 0, n_wb_seen = 0;
    int           m_hit = 0, m_miss = 0, m_wb = 0;
    int           fixed_lat = -1, wait_c = -1;
    logic         stall = 1'b0, seen_v = 1'b0, dead = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic bad(input string nm);
        n_chk++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic logic [127:0] init_line(input logic [31:0] blk);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = blk * 32'd2654435761 + 32'(k) * 32'h01010101;
        return l;
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] blk);
        return ref_mem.exists(blk) ? ref_mem[blk] : init_line(blk);
    endfunction

    task automatic model_access(input logic [31:0] a, input logic rw, input logic [31:0] wd, input logic [3:0] be);
        int s, wo, hi;
        logic [31:0] blk;
        ent_t e, v;
        s  = int'(a[9:4]);
        wo = int'(a[3:2]);
        hi = -1;
        for (int i = 0; i < cm[s].size(); i++) if (cm[s][i].tag == a[31:10]) hi = i;
        if (hi < 0) begin
            m_miss++;
            if (cm[s].size() == 2) begin
                v = cm[s].pop_back();
                if (v.dirty) begin
                    blk = {v.tag, a[9:4], 4'h0};
                    m_wb++;
                    ref_mem[blk] = v.line;
                    exp_mem.push_back('{1'b1, blk, v.line});
                end
            end
            blk = {a[31:10], a[9:4], 4'h0};
            exp_mem.push_back('{1'b0, blk, 128'h0});
            e = '{a[31:10], 1'b0, ref_line(blk)};
        end else begin
            e = cm[s][hi];
            cm[s].delete(hi);
        end
        m_hit++;
        if (rw) begin
            for (int b = 0; b < 4; b++) if (be[b]) e.line[wo*32 + b*8 +: 8] = wd[b*8 +: 8];
            e.dirty = 1'b1;
            exp_cpu.push_back('{1'b0, 32'h0});
        end else exp_cpu.push_back('{1'b1, e.line[wo*32 +: 32]});
        cm[s].push_front(e);
    endtask

    task automatic flush_model();
        for (int s = 0; s < 64; s++) cm[s].delete();
        exp_cpu.delete();
        exp_mem.delete();
        m_hit = 0; m_miss = 0; m_wb = 0;
    endtask

    task automatic access(input logic [31:0] a, input logic rw, input logic [31:0] wd, input logic [3:0] be,
                          output int cyc, output logic [31:0] rd);
        model_access(a, rw, wd, be);
        cpu_addr = a; cpu_rw = rw; cpu_wdata = wd; cpu_byte_en = be; cpu_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cpu_ready && cyc < 100);
        rd = cpu_rdata;
        if (!cpu_ready) begin
            bad("access_timeout");
            dead = 1'b1;
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
    endtask

    // Memory: sees a request one cycle after it appears, then answers after 0..3 (or fixed_lat) extra cycles.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (mem_ready || reset) begin
                mem_ready = 1'b0;
                wait_c = -1;
            end else if (seen_v && mem_valid && !stall) begin
                if (wait_c < 0) wait_c = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
                if (wait_c == 0) begin
                    if (mem_rw) env_mem[mem_addr] = mem_wdata;
                    else mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_line(mem_addr);
                    mem_ready = 1'b1;
                end
                wait_c--;
            end
        end
    end

    initial begin
        logic prev_v, prev_r, have_cur;
        cexp_t ce;
        mreq_t cur;
        prev_v = 1'b0; prev_r = 1'b0; have_cur = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            seen_v = mem_valid && !reset;
            if (!reset) begin
                if (cpu_ready) begin
                    if (exp_cpu.size() == 0) bad("cpu_unexpected");
                    else begin
                        ce = exp_cpu.pop_front();
                        if (ce.rd) chk("cpu_rdata", cpu_rdata, ce.data);
                    end
                end else chk("rdata_idle", cpu_rdata, 0);
                if (mem_valid) begin
                    if (!prev_v || prev_r) begin
                        if (mem_rw) n_wb_seen++;
                        have_cur = exp_mem.size() != 0;
                        if (have_cur) cur = exp_mem.pop_front();
                        else bad("mem_unexpected");
                    end
                    if (have_cur) begin
                        chk("mem_rw", mem_rw, cur.rw);
                        chk("mem_addr", mem_addr, cur.addr);
                        if (cur.rw) chk("mem_wdata", mem_wdata, cur.data);
                    end
                    chk("cpu_ready_during_mem", cpu_ready, 0);
                end
            end
            prev_v = mem_valid;
            prev_r = mem_ready;
        end
    end

    initial begin
        int cyc, wb0;
        logic [31:0] rd, a;
        logic [127:0] a_line;
        reset = 1'b1;
        cpu_addr = 32'h1004; cpu_wdata = '0; cpu_byte_en = '0; cpu_rw = 1'b0; cpu_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        reset = 1'b0;

        fixed_lat = 0;
        a_line = init_line(32'h1000);
        access(32'h1004, 0, 0, 4'h0, cyc, rd);
        chk("cold_latency", cyc, 3);
        chk("cold_rdata_A1", rd, a_line[63:32]);
        access(32'h1004, 0, 0, 4'h0, cyc, rd);
        chk("reread_latency", cyc, 1);
        access(32'h1000, 1, 32'h11223344, 4'hF, cyc, rd);
        chk("write_hit_latency", cyc, 1);
        access(32'h1000, 1, 32'hAABBCCDD, 4'b0010, cyc, rd);
        access(32'h1000, 0, 0, 4'h0, cyc, rd);
        chk("byte_merge", rd, 32'h1122CC44);
        fixed_lat = -1;

        access(32'h1400, 0, 0, 4'h0, cyc, rd);
        access(32'h1000, 1, 32'hCAFEF00D, 4'b1000, cyc, rd);
        wb0 = n_wb_seen;
        access(32'h1800, 0, 0, 4'h0, cyc, rd);
        chk("lru_clean_victim_no_wb", n_wb_seen - wb0, 0);
        access(32'h1C00, 0, 0, 4'h0, cyc, rd);
        chk("dirty_victim_wb", n_wb_seen - wb0, 1);

        access(32'h1C00, 1, 32'h01020304, 4'hF, cyc, rd);
        access(32'h1808, 1, 32'h05060708, 4'hF, cyc, rd);
        fixed_lat = 20;
        access(32'h2000, 0, 0, 4'h0, cyc, rd);
        chk("held_wb_long", cyc > 40, 1);
        fixed_lat = -1;

        stall = 1'b1;
        model_access(32'h5010, 0, 0, 4'h0);
        cpu_addr = 32'h5010; cpu_rw = 1'b0; cpu_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("alloc_pending_valid", mem_valid, 1);
        chk("alloc_pending_rw", mem_rw, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_valid = 1'b0;
        flush_model();
        @(posedge clk); #1;
        reset = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("post_reset_mem_valid", mem_valid, 0);
        @(posedge clk); #1;
        access(32'h5010, 0, 0, 4'h0, cyc, rd);
        chk("post_reset_remiss", cyc > 1, 1);

        for (int i = 0; i < 400 && !dead; i++) begin
            a = {22'($urandom_range(4, 9)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), cyc, rd);
        end

        repeat (3) @(negedge clk);
        chk("exp_cpu_drained", exp_cpu.size(), 0);
        chk("exp_mem_drained", exp_mem.size(), 0);
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, m_hit);
        chk("miss_cnt", miss_cnt, m_miss);
        chk("wb_cnt", wb_cnt, m_wb);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
